pipelined_cla_alu: RTL

- Parametrised, two-stage pipelined successor to the combinational carry-lookahead adder/comparator.
- Adds a multi-op ALU, a valid/ready handshake with backpressure, overflow and zero flags, and signed compare flags.
- Splits the carry chain across two register stages so wide datapaths (64 bits and above) close timing.
- Sits between the register-file read stage and writeback in the datapath.

---
 rtl/pipelined_cla_alu_if.sv | 30 +++
 rtl/pipelined_cla_alu.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_alu_if.sv
// Request/response bundle for pipelined_cla_alu: valid/ready request side plus registered result side.
interface pipelined_cla_alu_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op_i;
    logic [DATA_WIDTH-1:0] op1_i;
    logic [DATA_WIDTH-1:0] op2_i;
    logic                  cin_i;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] res_o;
    logic                  cout_o;
    logic                  ovf_o;
    logic                  zero_o;
    logic                  a_gt_b;
    logic                  a_lt_b;
    logic                  a_eq_b;

    modport master (
        output in_valid, op_i, op1_i, op2_i, cin_i, out_ready,
        input  in_ready, out_valid, res_o, cout_o, ovf_o, zero_o, a_gt_b, a_lt_b, a_eq_b
    );

    modport slave (
        input  in_valid, op_i, op1_i, op2_i, cin_i, out_ready,
        output in_ready, out_valid, res_o, cout_o, ovf_o, zero_o, a_gt_b, a_lt_b, a_eq_b
    );
endinterface

// File: rtl/pipelined_cla_alu.sv
// Two-stage pipelined CLA ALU: lower-half sum in S1, upper-half sum, flags and result mux in S2.
// Define ALU_SATURATE_EN to clamp overflowing ADD/SUB results instead of wrapping.
module pipelined_cla_alu #(
    parameter int DATA_WIDTH  = 64,
    parameter int GROUP_WIDTH = 4
) (
    input logic                clk,
    input logic                reset,
    pipelined_cla_alu_if.slave bus
);
    localparam int HALF    = DATA_WIDTH / 2;
    localparam int NGROUPS = HALF / GROUP_WIDTH;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_AND    = 3'b010,
        OP_OR     = 3'b011,
        OP_XOR    = 3'b100,
        OP_SLT    = 3'b101,
        OP_PASS_A = 3'b110,
        OP_PASS_B = 3'b111
    } op_t;

    // Half-width adder: lookahead inside each group, group carries chained between groups.
    function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] a,
                                               input logic [HALF-1:0] b,
                                               input logic            c_in);
        logic [HALF-1:0] g;
        logic [HALF-1:0] p;
        logic [HALF-1:0] sum;
        logic            grp_c;
        logic            gg;
        logic            pp;
        int              idx;
        g     = a & b;
        p     = a ^ b;
        sum   = '0;
        grp_c = c_in;
        for (int grp = 0; grp < NGROUPS; grp++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int k = 0; k < GROUP_WIDTH; k++) begin
                idx      = grp * GROUP_WIDTH + k;
                sum[idx] = p[idx] ^ (gg | (pp & grp_c));
                gg       = g[idx] | (p[idx] & gg);
                pp       = pp & p[idx];
            end
            grp_c = gg | (pp & grp_c);
        end
        return {grp_c, sum};
    endfunction

    logic adv;

    op_t                   in_op;
    logic                  in_sub;
    logic [DATA_WIDTH-1:0] b_eff;
    logic                  cin_eff;
    logic [HALF:0]         lo_add;
    logic [DATA_WIDTH-1:0] logic_res;

    logic                  s1_valid;
    op_t                   s1_op;
    logic [HALF-1:0]       s1_sum_lo;
    logic                  s1_c_half;
    logic [HALF-1:0]       s1_b_hi;
    logic [DATA_WIDTH-1:0] s1_a;
    logic [DATA_WIDTH-1:0] s1_b;
    logic [DATA_WIDTH-1:0] s1_logic;

    logic [HALF:0]         hi_add;
    logic [DATA_WIDTH-1:0] sum;
    logic                  arith;
    logic                  ovf;
    logic                  lt;
    logic                  eq;
    logic [DATA_WIDTH-1:0] res;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        in_op   = op_t'(bus.op_i);
        in_sub  = (in_op == OP_SUB);
        b_eff   = in_sub ? ~bus.op2_i : bus.op2_i;
        cin_eff = in_sub | ((in_op == OP_ADD) & bus.cin_i);
        lo_add  = cla_half(bus.op1_i[HALF-1:0], b_eff[HALF-1:0], cin_eff);
        case (in_op)
            OP_AND:    logic_res = bus.op1_i & bus.op2_i;
            OP_OR:     logic_res = bus.op1_i | bus.op2_i;
            OP_XOR:    logic_res = bus.op1_i ^ bus.op2_i;
            OP_PASS_A: logic_res = bus.op1_i;
            OP_PASS_B: logic_res = bus.op2_i;
            default:   logic_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_op     <= OP_ADD;
            s1_sum_lo <= '0;
            s1_c_half <= 1'b0;
            s1_b_hi   <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_logic  <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op     <= in_op;
                s1_sum_lo <= lo_add[HALF-1:0];
                s1_c_half <= lo_add[HALF];
                s1_b_hi   <= b_eff[DATA_WIDTH-1:HALF];
                s1_a      <= bus.op1_i;
                s1_b      <= bus.op2_i;
                s1_logic  <= logic_res;
            end
        end
    end

    // s1_b_hi already holds ~B for SUB, so its MSB is the sign of B' in the overflow rule.
    always_comb begin
        hi_add = cla_half(s1_a[DATA_WIDTH-1:HALF], s1_b_hi, s1_c_half);
        sum    = {hi_add[HALF-1:0], s1_sum_lo};
        arith  = (s1_op == OP_ADD) || (s1_op == OP_SUB);
        ovf    = arith && (s1_a[DATA_WIDTH-1] == s1_b_hi[HALF-1])
                       && (sum[DATA_WIDTH-1] != s1_a[DATA_WIDTH-1]);
        lt     = $signed(s1_a) < $signed(s1_b);
        eq     = (s1_a == s1_b);
        case (s1_op)
            OP_ADD, OP_SUB: res = sum;
            OP_SLT:         res = {{(DATA_WIDTH-1){1'b0}}, lt};
            default:        res = s1_logic;
        endcase
`ifdef ALU_SATURATE_EN
        if (ovf) begin
            res = s1_a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.res_o     <= '0;
            bus.cout_o    <= 1'b0;
            bus.ovf_o     <= 1'b0;
            bus.zero_o    <= 1'b0;
            bus.a_gt_b    <= 1'b0;
            bus.a_lt_b    <= 1'b0;
            bus.a_eq_b    <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.res_o  <= res;
                bus.cout_o <= arith & hi_add[HALF];
                bus.ovf_o  <= ovf;
                bus.zero_o <= (res == '0);
                bus.a_gt_b <= !lt && !eq;
                bus.a_lt_b <= lt;
                bus.a_eq_b <= eq;
            end
        end
    end
endmodule
